cci_mpf_shim_wro_afu_buf: RTL and testbench

CCI_MPF_SHIM_WRO_AFU_BUF -- requirements
Module: cci_mpf_shim_wro_afu_buf

---
 rtl/cci_mpf_shim_wro_afu_buf.sv | 87 ++++++++
 tb/tb_cci_mpf_shim_wro_afu_buf.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_shim_wro_afu_buf.sv
// cci_mpf_shim_wro_afu_buf
// Show-ahead request buffer between the AFU and the WRO filter stage.
// The AFU has no ready signal. It is throttled by almost_full, which is
// registered and leaves THRESHOLD slots of slack for requests already in flight.
// Optional build macro CCI_MPF_WRO_AFU_BUF_STATS_EN enables occupancy
// high-water tracking on max_occupancy. When the macro is undefined,
// max_occupancy is tied to 0.
module cci_mpf_shim_wro_afu_buf #(
   parameter int DATA_WIDTH = 128,
   parameter int N_ENTRIES  = 16,
   parameter int THRESHOLD  = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic [DATA_WIDTH-1:0]          in_data,
   output logic                           almost_full,
   output logic                           out_valid,
   output logic [DATA_WIDTH-1:0]          out_data,
   input  logic                           out_deq,
   output logic                           overflow,
   output logic                           underflow,
   output logic [$clog2(N_ENTRIES):0]     max_occupancy
);

   localparam int PTR_W = $clog2(N_ENTRIES);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_ENTRIES);
   // (N_ENTRIES - c) <= THRESHOLD is the same test as c >= N_ENTRIES - THRESHOLD.
   localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(N_ENTRIES - THRESHOLD);

   logic [DATA_WIDTH-1:0] mem [N_ENTRIES];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count, count_next;
   logic                  deq_ok, accept, drop, bad_deq;

   // A dequeue counts only when the head is valid.
   // A full buffer still accepts a write when a dequeue frees the slot in the same cycle.
   always_comb begin
      deq_ok  = out_deq & (count != '0);
      accept  = in_valid & ((count != FULL_CNT) | deq_ok);
      drop    = in_valid & (count == FULL_CNT) & ~deq_ok;
      bad_deq = out_deq & (count == '0);
      count_next = count;
      if (accept && !deq_ok)      count_next = count + CNT_W'(1);
      else if (!accept && deq_ok) count_next = count - CNT_W'(1);
   end

   // Show-ahead head, driven only from registered state (no write bypass).
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   // The storage array has no reset. Stale entries are unreachable once count is cleared.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= in_data;
   end

   // Pointers, count, registered almost_full and sticky error flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         count       <= count_next;
         almost_full <= (count_next >= AF_LEVEL);
         if (drop)    overflow  <= 1'b1;
         if (bad_deq) underflow <= 1'b1;
      end
   end

`ifdef CCI_MPF_WRO_AFU_BUF_STATS_EN
   // High-water mark of occupancy, compared against the count for the next cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          max_occupancy <= '0;
      else if (count_next > max_occupancy) max_occupancy <= count_next;
   end
`else
   assign max_occupancy = '0;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_wro_afu_buf.sv
// Directed bench for cci_mpf_shim_wro_afu_buf with default parameters.
// The expected max_occupancy follows CCI_MPF_WRO_AFU_BUF_STATS_EN.
module tb_cci_mpf_shim_wro_afu_buf;

   localparam int DW = 128;
   localparam int N  = 16;
   localparam int TH = 8;

`ifdef CCI_MPF_WRO_AFU_BUF_STATS_EN
   localparam logic [4:0] EXP_PEAK = 5'd11;
`else
   localparam logic [4:0] EXP_PEAK = 5'd0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_deq = 1'b0;
   logic          almost_full, out_valid, overflow, underflow;
   logic [DW-1:0] out_data;
   logic [4:0]    max_occupancy;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] exp_d;

   cci_mpf_shim_wro_afu_buf #(.DATA_WIDTH(DW), .N_ENTRIES(N), .THRESHOLD(TH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .almost_full(almost_full), .out_valid(out_valid), .out_data(out_data),
      .out_deq(out_deq), .overflow(overflow), .underflow(underflow),
      .max_occupancy(max_occupancy));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; out_deq = 1'b0;
      #2;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      in_valid = 1'b1; in_data = 128'h5;
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_almost_full: got %b want 0", almost_full); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b%b want 00", overflow, underflow); end
      checks++; if (max_occupancy !== 5'd0) begin errors++; $display("FAIL rst_max_occ: got %0d want 0", max_occupancy); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ignore_in: got %b want 0", out_valid); end
      reset = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 128'h5) begin errors++; $display("FAIL rst_first_accept: got %b/%0h want 1/5", out_valid, out_data); end
      in_valid = 1'b0;
      do_reset();
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         tick();
         if (i == 7) begin
            checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL fill_af7: got %b want 0", almost_full); end
         end
         if (i == 8) begin
            checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_af8: got %b want 1", almost_full); end
         end
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 128'h1) begin errors++; $display("FAIL fill_head: got %b/%0h want 1/1", out_valid, out_data); end
      do_reset();
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 17; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         tick();
         if (i == 16) begin
            checks++; if (overflow !== 1'b0 || almost_full !== 1'b1) begin errors++; $display("FAIL ovf_at16: got ovf=%b af=%b want 0/1", overflow, almost_full); end
         end
      end
      in_valid = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      for (int i = 1; i <= 16; i++) begin
         exp_d = DW'(i);
         checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL ovf_drain%0d: got %b/%0h want 1/%0h", i, out_valid, out_data, exp_d); end
         out_deq = 1'b1;
         tick();
         checks++; if (almost_full !== (i <= 8)) begin errors++; $display("FAIL ovf_af_drain%0d: got %b want %b", i, almost_full, (i <= 8)); end
      end
      out_deq = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
      checks++; if (overflow !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL ovf_sticky: got ovf=%b unf=%b want 1/0", overflow, underflow); end
      #2 reset = 1'b1;
      #1;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset_clear: got %b want 0", overflow); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_full_simul();
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1; in_data = DW'(32'h100 + i);
         tick();
      end
      in_valid = 1'b1; in_data = 128'h200; out_deq = 1'b1;
      tick();
      in_valid = 1'b0; out_deq = 1'b0;
      checks++; if (overflow !== 1'b0 || out_valid !== 1'b1 || almost_full !== 1'b1) begin errors++; $display("FAIL full_simul_state: got ovf=%b ov=%b af=%b want 0/1/1", overflow, out_valid, almost_full); end
      for (int i = 2; i <= 17; i++) begin
         exp_d = (i == 17) ? 128'h200 : DW'(32'h100 + i);
         checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL full_simul_drain%0d: got %b/%0h want 1/%0h", i, out_valid, out_data, exp_d); end
         out_deq = 1'b1;
         tick();
      end
      out_deq = 1'b0;
      checks++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL full_simul_end: got ov=%b ovf=%b want 0/0", out_valid, overflow); end
      do_reset();
   endtask

   task automatic test_empty_corner();
      in_valid = 1'b1; in_data = 128'hA; out_deq = 1'b1;
      tick();
      in_valid = 1'b0; out_deq = 1'b0;
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_underflow: got %b want 1", underflow); end
      checks++; if (out_valid !== 1'b1 || out_data !== 128'hA) begin errors++; $display("FAIL empty_head: got %b/%0h want 1/a", out_valid, out_data); end
      out_deq = 1'b1;
      tick();
      out_deq = 1'b0;
      checks++; if (out_valid !== 1'b0 || underflow !== 1'b1) begin errors++; $display("FAIL empty_after: got ov=%b unf=%b want 0/1", out_valid, underflow); end
      do_reset();
   endtask

   task automatic test_wrap_reset();
      in_valid = 1'b1; in_data = 128'h300;
      tick();
      for (int i = 1; i < 40; i++) begin
         exp_d = DW'(32'h300 + i - 1);
         in_data = DW'(32'h300 + i); out_deq = 1'b1;
         checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin errors++; $display("FAIL wrap%0d: got %b/%0h want 1/%0h", i, out_valid, out_data, exp_d); end
         tick();
      end
      in_valid = 1'b0;
      checks++; if (out_data !== 128'h327) begin errors++; $display("FAIL wrap_last: got %0h want 327", out_data); end
      tick();
      out_deq = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b want 0", out_valid); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         tick();
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_cnt5: got %b want 1", out_valid); end
      #2 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL async_reset: got ov=%b af=%b want 0/0", out_valid, almost_full); end
      checks++; if (max_occupancy !== 5'd0) begin errors++; $display("FAIL async_reset_max: got %0d want 0", max_occupancy); end
      reset = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard: got %b want 0", out_valid); end
   endtask

   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 11; i++) begin
         in_valid = 1'b1; in_data = DW'(i);
         tick();
      end
      in_valid = 1'b0;
      checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL stats_af: got %b want 1", almost_full); end
      out_deq = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      out_deq = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stats_drained: got %b want 0", out_valid); end
      checks++; if (max_occupancy !== EXP_PEAK) begin errors++; $display("FAIL stats_peak: got %0d want %0d", max_occupancy, EXP_PEAK); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_full_simul();
      test_empty_corner();
      test_wrap_reset();
      test_stats();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
